// File: rtl/lat_result_mailbox.sv
// Latency-result mailbox: buffers saturated timer samples in a FIFO and serves them to the HPS
// through a toggle-handshaked PIO command/response pair. Optional stats: LAT_MAILBOX_STATS_EN.
module lat_result_mailbox #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic        CLOCK_50,
   input  logic        reset_n,
   input  logic        sample_valid,
   input  logic [31:0] sample_data,
   input  logic [31:0] pio_cmd,
   output logic [31:0] pio_rsp,
   output logic [3:0]  fifo_level,
   output logic        overflow
);

   typedef enum logic [0:0] {StIdle, StExec} state_t;

   localparam logic [3:0] OpPop      = 4'h1;
   localparam logic [3:0] OpStatus   = 4'h2;
   localparam logic [3:0] OpReadMin  = 4'h3;
   localparam logic [3:0] OpReadMax  = 4'h4;
   localparam logic [3:0] OpClear    = 4'h5;
   localparam logic [3:0] OpReadCnt  = 4'h6;
   localparam logic [1:0] StatOk     = 2'b00;
   localparam logic [1:0] StatEmpty  = 2'b01;
   localparam logic [1:0] StatBadOp  = 2'b10;
   localparam logic [3:0] LevelFull  = 4'(DEPTH);

   logic [23:0]       r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [3:0]        r_level;
   logic              r_overflow;
   logic [31:0]       r_rsp;
   logic              r_last_tog;
   logic [4:0]        r_cmd_q;
   state_t            r_state;

   logic [ADDR_W-1:0] w_wr_ptr_d, w_rd_ptr_d;
   logic [3:0]        w_level_d;
   logic              w_overflow_d;
   logic [31:0]       w_rsp_d;
   logic              w_exec, w_pop, w_clr, w_push, w_space;
   logic [1:0]        w_status;
   logic [23:0]       w_data, w_sat;
   logic [3:0]        w_op;
   logic              w_unused_cmd;

   assign w_unused_cmd = ^pio_cmd[26:0];
   assign w_exec       = (r_state == StExec);
   assign w_op         = r_cmd_q[4:1];
   assign w_sat        = (|sample_data[31:24]) ? 24'hFF_FFFF : sample_data[23:0];

`ifdef LAT_MAILBOX_STATS_EN
   logic [23:0] r_min, r_max;
   logic [15:0] r_count;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_min   <= 24'hFF_FFFF;
         r_max   <= 24'h0;
         r_count <= 16'h0;
      end else if (w_clr) begin
         r_min   <= 24'hFF_FFFF;
         r_max   <= 24'h0;
         r_count <= 16'h0;
      end else if (w_push) begin
         if (w_sat < r_min) r_min <= w_sat;
         if (w_sat > r_max) r_max <= w_sat;
         if (r_count != 16'hFFFF) r_count <= r_count + 16'h1;
      end
   end
`endif

   always_comb begin
      w_pop    = 1'b0;
      w_clr    = 1'b0;
      w_status = StatOk;
      w_data   = 24'h0;
      if (w_exec) begin
         unique case (w_op)
            OpPop: begin
               if (r_level != 4'h0) begin
                  w_pop  = 1'b1;
                  w_data = r_mem[r_rd_ptr];
               end else begin
                  w_status = StatEmpty;
               end
            end
            OpStatus: ;
            OpClear:  w_clr = 1'b1;
`ifdef LAT_MAILBOX_STATS_EN
            OpReadMin: w_data = r_min;
            OpReadMax: w_data = r_max;
            OpReadCnt: w_data = {8'h0, r_count};
`endif
            default:  w_status = StatBadOp;
         endcase
      end
   end

   // A same-cycle pop frees the slot the incoming sample needs.
   assign w_space = (r_level != LevelFull) || w_pop;
   assign w_push  = sample_valid && !w_clr && w_space;

   always_comb begin
      w_wr_ptr_d   = r_wr_ptr;
      w_rd_ptr_d   = r_rd_ptr;
      w_level_d    = r_level;
      w_overflow_d = r_overflow;
      if (w_clr) begin
         w_wr_ptr_d   = '0;
         w_rd_ptr_d   = '0;
         w_level_d    = 4'h0;
         w_overflow_d = 1'b0;
      end else begin
         if (sample_valid && !w_space) w_overflow_d = 1'b1;
         if (w_pop)  w_rd_ptr_d = r_rd_ptr + 1'b1;
         if (w_push) w_wr_ptr_d = r_wr_ptr + 1'b1;
         w_level_d = r_level + {3'b000, w_push} - {3'b000, w_pop};
      end
      w_rsp_d = r_rsp;
      if (w_exec) w_rsp_d = {r_cmd_q[0], w_overflow_d, w_status, w_level_d, w_data};
   end

   always_ff @(posedge CLOCK_50) begin
      if (w_push) r_mem[r_wr_ptr] <= w_sat;
   end

   // The toggle is compared on the incoming word while it is being registered, so the
   // response lands two clocks after the command word changes.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= 4'h0;
         r_overflow <= 1'b0;
         r_rsp      <= 32'h0;
         r_last_tog <= 1'b0;
         r_cmd_q    <= 5'h0;
         r_state    <= StIdle;
      end else begin
         r_cmd_q    <= pio_cmd[31:27];
         r_wr_ptr   <= w_wr_ptr_d;
         r_rd_ptr   <= w_rd_ptr_d;
         r_level    <= w_level_d;
         r_overflow <= w_overflow_d;
         r_rsp      <= w_rsp_d;
         unique case (r_state)
            StIdle: begin
               if (pio_cmd[27] != r_last_tog) begin
                  r_last_tog <= pio_cmd[27];
                  r_state    <= StExec;
               end
            end
            StExec:  r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
      end
   end

   assign pio_rsp    = r_rsp;
   assign fifo_level = r_level;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_lat_result_mailbox.sv
// Directed scoreboard bench for lat_result_mailbox; expected responses come from a queue model.
module tb_lat_result_mailbox;

   localparam int unsigned DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        sample_valid;
   logic [31:0] sample_data;
   logic [31:0] pio_cmd;
   logic [31:0] pio_rsp;
   logic [3:0]  fifo_level;
   logic        overflow;

   int n_pass  = 0;
   int n_total = 0;

   logic [23:0] mq[$];
   logic [31:0] sb[$];
   bit          movf;
   bit          tog;
   logic [31:0] prev_rsp;
   logic [23:0] m_min, m_max;
   logic [15:0] m_cnt;

   lat_result_mailbox #(.DEPTH(8), .ADDR_W(3)) dut (
      .CLOCK_50     (clk),
      .reset_n      (reset_n),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .pio_cmd      (pio_cmd),
      .pio_rsp      (pio_rsp),
      .fifo_level   (fifo_level),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [23:0] sat(input logic [31:0] d);
      return (d > 32'h00FF_FFFF) ? 24'hFF_FFFF : d[23:0];
   endfunction

   task automatic stats_reset();
      m_min = 24'hFF_FFFF;
      m_max = 24'h0;
      m_cnt = 16'h0;
   endtask

   task automatic model_store(input logic [31:0] d);
      if (mq.size() < DEPTH) begin
         mq.push_back(sat(d));
         if (sat(d) < m_min) m_min = sat(d);
         if (sat(d) > m_max) m_max = sat(d);
         if (m_cnt != 16'hFFFF) m_cnt++;
      end else begin
         movf = 1'b1;
      end
   endtask

   task automatic push(input logic [31:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      model_store(d);
   endtask

   task automatic check_state(input string tag);
      check({tag, "_level"}, {28'h0, fifo_level}, 32'(mq.size()));
      check({tag, "_ovf"}, {31'h0, overflow}, {31'h0, movf});
   endtask

   // Issue one command; optionally pulse a sample during its EXEC cycle.
   task automatic do_cmd(input string tag, input logic [3:0] op, input bit with_s,
                         input logic [31:0] sdata);
      logic [23:0] data;
      logic [1:0]  st;
      data = 24'h0;
      st   = 2'b00;
      tog  = ~tog;
      pio_cmd = {op, tog, 27'($urandom)};
      case (op)
         4'h1: if (mq.size() > 0) data = mq.pop_front(); else st = 2'b01;
         4'h2: ;
         4'h5: begin
            mq.delete();
            movf = 1'b0;
            stats_reset();
         end
`ifdef LAT_MAILBOX_STATS_EN
         4'h3: data = m_min;
         4'h4: data = m_max;
         4'h6: data = {8'h0, m_cnt};
`endif
         default: st = 2'b10;
      endcase
      if (with_s && op != 4'h5) model_store(sdata);
      sb.push_back({tog, movf, st, 4'(mq.size()), data});
      @(posedge clk); #1;
      check({tag, "_latency"}, pio_rsp, prev_rsp);
      if (with_s) begin
         sample_valid = 1'b1;
         sample_data  = sdata;
      end
      @(posedge clk); #1;
      sample_valid = 1'b0;
      prev_rsp = sb.pop_front();
      check(tag, pio_rsp, prev_rsp);
   endtask

   initial begin
      reset_n      = 1'b0;
      sample_valid = 1'b0;
      sample_data  = 32'h0;
      pio_cmd      = 32'h0;
      tog          = 1'b0;
      movf         = 1'b0;
      prev_rsp     = 32'h0;
      stats_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_rsp", pio_rsp, 32'h0);
      check_state("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;

      do_cmd("status_first", 4'h2, 1'b0, 32'h0);
      check("status_literal", pio_rsp, 32'h8000_0000);

      push(32'd100);
      push(32'd200);
      push(32'd300);
      do_cmd("pop_100", 4'h1, 1'b0, 32'h0);
      check("pop_100_literal", pio_rsp, 32'h0200_0064);
      do_cmd("pop_200", 4'h1, 1'b0, 32'h0);
      check("pop_200_literal", pio_rsp, 32'h8100_00C8);
      repeat (4) @(posedge clk);
      #1;
      check("rsp_hold", pio_rsp, prev_rsp);
      check_state("no_reexec");

      do_cmd("clear_a", 4'h5, 1'b0, 32'h0);
      for (int i = 0; i < 9; i++) push(32'(i * 1000 + 5));
      check_state("overfill");
      check("overfill_ovf_lit", {31'h0, overflow}, 32'h1);
      do_cmd("status_full", 4'h2, 1'b0, 32'h0);
      check("status_full_bits", {28'h0, pio_rsp[30], pio_rsp[27:24]}, 32'h18);
      do_cmd("clear_b", 4'h5, 1'b0, 32'h0);
      check_state("after_clear");

      push(32'h0200_0000);
      do_cmd("pop_sat", 4'h1, 1'b0, 32'h0);
      check("pop_sat_data", {8'h0, pio_rsp[23:0]}, 32'h00FF_FFFF);
      do_cmd("pop_empty", 4'h1, 1'b0, 32'h0);
      check("pop_empty_status", {30'h0, pio_rsp[29:28]}, 32'h1);

      for (int i = 0; i < 8; i++) push(32'(16 * i + 3));
      do_cmd("pop_full_push", 4'h1, 1'b1, 32'h00AB_CDEF);
      check_state("full_push");
      do_cmd("badop7", 4'h7, 1'b0, 32'h0);
      check_state("badop7");
      for (int i = 0; i < 8; i++) do_cmd("drain", 4'h1, 1'b0, 32'h0);
      check("drain_last", {8'h0, pio_rsp[23:0]}, 32'h00AB_CDEF);

      do_cmd("clear_c", 4'h5, 1'b0, 32'h0);
      push(32'd50);
      push(32'd10);
      push(32'd70);
      do_cmd("read_min", 4'h3, 1'b0, 32'h0);
      do_cmd("read_max", 4'h4, 1'b0, 32'h0);
      do_cmd("read_cnt", 4'h6, 1'b0, 32'h0);

      do_cmd("clear_with_sample", 4'h5, 1'b1, 32'd77);
      check_state("clear_with_sample");

      for (int i = 0; i < 9; i++) push(32'(i + 1));
      tog = ~tog;
      pio_cmd = {4'h2, tog, 27'h0};
      @(posedge clk); #1;
      reset_n = 1'b0;
      pio_cmd = 32'h0;
      #1;
      check("midexec_rst_rsp", pio_rsp, 32'h0);
      check("midexec_rst_level", {28'h0, fifo_level}, 32'h0);
      check("midexec_rst_ovf", {31'h0, overflow}, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      mq.delete();
      movf = 1'b0;
      tog = 1'b0;
      prev_rsp = 32'h0;
      stats_reset();
      @(posedge clk); #1;
      do_cmd("status_after_rst", 4'h2, 1'b0, 32'h0);
      check("status_after_rst_lit", pio_rsp, 32'h8000_0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/lat_result_mailbox.md
Name: lat_result_mailbox

Overview:
- Downstream of the ARM↔FPGA latency timer.
- Captures each completed cycle-count measurement into a small FIFO.
- Serves the buffered results to the HPS over a PIO command/response word pair.
- The HPS can drain many measurements per run without re-arming the timer for every read.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..8
ADDR_W, 3, log2(DEPTH)

Ports:
CLOCK_50  input  1  system clock; all logic on the rising edge
reset_n  input  1  asynchronous, active-low reset
sample_valid  input  1  one-cycle pulse from the timer: measurement complete
sample_data  input  32  cycle count for that measurement
pio_cmd  input  32  command word from HPS output PIO (same clock domain)
pio_rsp  output  32  response word to HPS input PIO
fifo_level  output  4  current entry count, 0..DEPTH
overflow  output  1  sticky: a sample was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync release): FIFO empty, pointers 0, fifo_level=0, overflow=0, pio_rsp=32'h0, last_tog=0, cmd_q=0, FSM=IDLE.
- Push and stored data:
  - sample_data is saturated to 24 bits before storage: values >24'hFFFFFF are stored as 24'hFFFFFF.
  - On sample_valid with level<DEPTH: write at wr_ptr, then wr_ptr+1 (wraps mod DEPTH), then level+1.
  - On sample_valid with level==DEPTH and no same-cycle pop: sample dropped, overflow←1.
- Command decode:
  - pio_cmd is registered into cmd_q every cycle.
  - Fields: opcode = cmd_q[31:28], tog = cmd_q[27]. Bits [26:0] are ignored.
  - A command is issued when tog != last_tog. Level-held commands never re-execute.
- FSM:
  - IDLE: on a new tog, capture opcode, last_tog←tog, go to EXEC.
  - EXEC (1 cycle): perform the op, register pio_rsp, return to IDLE.
  - A tog change during EXEC is seen in the next IDLE cycle. The HPS is required to wait for the echo before toggling again.
- Response latency: pio_rsp is updated exactly 2 cycles after pio_cmd changes. It holds until the next command.
- pio_rsp format:
  - [31]: echo of tog.
  - [30]: overflow.
  - [29:28]: status. 00 OK, 01 EMPTY, 10 BADOP.
  - [27:24]: level after the op.
  - [23:0]: data.
- Opcodes:
  - 0x1 POP: if level>0, data=head, rd_ptr+1, level-1, status OK. If empty, data=0, status EMPTY.
  - 0x2 STATUS: data=0, status OK. No state change.
  - 0x5 CLEAR: pointers and level←0, overflow←0, data=0, status OK.
  - All other opcodes: status BADOP, data=0, no state change.
- Simultaneous events:
  - POP and sample_valid in the same cycle when full: both succeed, level stays DEPTH, no overflow.
  - POP and sample_valid when empty: POP returns EMPTY, the sample is stored, level=1.
  - CLEAR and sample_valid in the same cycle: CLEAR wins and the sample is discarded; overflow is not set.
- Reset mid-operation: everything returns to reset values immediately, including during EXEC. last_tog=0, so the HPS restarts with tog=1.
- fifo_level and overflow reflect register state with no added latency.

Optional Feature:
- Macro: LAT_MAILBOX_STATS_EN.
- When defined:
  - Tracks min and max of stored (saturated) samples, plus a 16-bit accepted-sample count that saturates at 16'hFFFF.
  - Reset and CLEAR values: min=24'hFFFFFF, max=0, count=0.
  - Added opcodes: 0x3 READ_MIN, 0x4 READ_MAX, 0x6 READ_COUNT (count zero-extended to 24 bits), all status OK.
  - Dropped samples do not update the stats.
- When undefined: 0x3, 0x4 and 0x6 return BADOP, and no stats registers exist.

Test Plan:
- Reset, then pio_cmd=32'h2800_0000 (STATUS, tog=1) → 2 cycles later pio_rsp=32'h8000_0000.
- Push samples 100, 200, 300; POP tog=0 (32'h1000_0000) → pio_rsp=32'h0200_0064. Next POP tog=1 → 32'h8100_00C8.
- Push 9 samples with DEPTH=8 → overflow=1, fifo_level=8. STATUS → pio_rsp[30]=1, [27:24]=8. CLEAR → overflow=0, level=0.
- Push sample_data=32'h0200_0000, then POP → data 24'hFFFFFF. POP again → status EMPTY, pio_rsp[29:28]=01, data 0.
- With FIFO full, pulse sample_valid in the EXEC cycle of a POP → level stays 8, overflow stays 0, and the new sample is read back last. Opcode 0x7 → BADOP, level unchanged.
- With LAT_MAILBOX_STATS_EN: push 50, 10, 70 → READ_MIN data 10, READ_MAX data 70, READ_COUNT data 3. Without the macro, READ_MIN → BADOP.
